// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic {
    IDLE,
    PRESSED
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_class_e;

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side pins and accepted-key outputs; master is the scanner, slave its environment.
interface keypad_scan_if;

  logic [keypad_pkg::NUM_ROWS-1:0] row_in;
  logic [keypad_pkg::NUM_COLS-1:0] col_out;
  logic [3:0]                      key_code;
  logic                            key_valid;
  logic                            key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/keypad_scan_timer.sv
// Column-slot divider: drives one active-low column per SCAN_DIV cycles and flags
// the sampling tick and the end of a full four-column scan.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [$clog2(NUM_COLS)-1:0] col_idx,
  output logic [NUM_COLS-1:0]         col_out,
  output logic                        tick,
  output logic                        scan_done
);

  localparam int                      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int                      COL_W    = $clog2(NUM_COLS);
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]        COL_LAST = COL_W'(NUM_COLS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [COL_W-1:0] col_next;

  assign tick      = (div_cnt == DIV_LAST);
  assign scan_done = tick && (col_idx == COL_LAST);
  assign col_next  = col_idx + COL_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      col_idx <= '0;
      col_out <= 4'b1110;
    end else if (tick) begin
      div_cnt <= '0;
      col_idx <= col_next;
      col_out <= ~(NUM_COLS'(1) << col_next);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: synchronizes rows, builds a 16-bit scan image, debounces the
// classified scans and emits one key code per accepted press.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master bus
);

  localparam int               COL_W   = $clog2(NUM_COLS);
  localparam int               CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [COL_W-1:0]    col_idx;
  logic [NUM_COLS-1:0] col_out;
  logic                tick;
  logic                scan_done;

  keypad_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .col_idx   (col_idx),
    .col_out   (col_out),
    .tick      (tick),
    .scan_done (scan_done)
  );

  assign bus.col_out = col_out;

  // Two-flop synchronizer; idle rows read as released (all ones).
  logic [NUM_ROWS-1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.row_in;
      sync2 <= sync1;
    end
  end

  // NOTE: the scan image has no reset: columns 0..2 are always rewritten after
  // reset before the first scan_done reads them, and column 3 comes straight from sync2.
  logic [NUM_ROWS-1:0] image [NUM_COLS];

  always_ff @(posedge clk) begin
    if (tick) image[col_idx] <= sync2;
  end

  // Classifier sees the finished image, including the column sampled this cycle.
  logic [NUM_ROWS-1:0] full_img [NUM_COLS];
  logic [4:0]          low_cnt;
  logic [3:0]          scan_code;
  scan_class_e         scan_cls;

  // NOTE: every variable gets a default at the top of the block so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) full_img[c] = image[c];
    full_img[col_idx] = sync2;
    low_cnt   = '0;
    scan_code = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!full_img[c][r]) begin
          low_cnt   = low_cnt + 5'd1;
          scan_code = 4'(r * NUM_COLS + c);
        end
      end
    end
    if (low_cnt == 5'd0)      scan_cls = NONE;
    else if (low_cnt == 5'd1) scan_cls = SINGLE;
    else                      scan_cls = MULTI;
  end

  // Stability tracking across consecutive full scans.
  scan_class_e      prev_cls;
  logic [3:0]       prev_code;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             same_class;
  logic             stable;

  assign same_class = (scan_cls == prev_cls) &&
                      ((scan_cls != SINGLE) || (scan_code == prev_code));
  assign cnt_next   = !same_class             ? CNT_W'(1) :
                      (stable_cnt == CNT_MAX) ? CNT_MAX   :
                                                stable_cnt + CNT_W'(1);
  assign stable     = (cnt_next == CNT_MAX);

  // FSM: next state and next output values.
  kp_state_e  state, state_next;
  logic [3:0] key_code, code_next;
  logic       key_valid, valid_next;
  logic       key_held, held_next;

  always_comb begin
    state_next = state;
    code_next  = key_code;
    valid_next = 1'b0;
    held_next  = key_held;
    if (scan_done && stable) begin
      unique case (state)
        IDLE: begin
          if (scan_cls == SINGLE) begin
            state_next = PRESSED;
            code_next  = scan_code;
            valid_next = 1'b1;
            held_next  = 1'b1;
          end
        end
        PRESSED: begin
          if (scan_cls == NONE) begin
            state_next = IDLE;
            held_next  = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      key_code  <= code_next;
      key_valid <= valid_next;
      key_held  <= held_next;
    end
  end

  // A transition restarts the count so the opposite event needs a fresh run.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cls   <= NONE;
      prev_code  <= '0;
      stable_cnt <= '0;
    end else if (scan_done) begin
      prev_cls   <= scan_cls;
      prev_code  <= scan_code;
      stable_cnt <= (state_next != state) ? '0 : cnt_next;
    end
  end

  assign bus.key_code  = key_code;
  assign bus.key_valid = key_valid;
  assign bus.key_held  = key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a switch-matrix model shorts row r to column c
// for every pressed key; vectors and sequences check pulses, code and held state.
module tb_keypad_scan;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int SCAN_CYC       = SCAN_DIV * 4;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  logic [3:0]  row_model;
  int          checks;
  int          errors;

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.col_out[c]) row_model[r] = 1'b0;
  end
  assign kif.row_in = row_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advances n clocks, sampling at each negedge; counts key_valid cycles.
  task automatic run_cycles(input int n, output int pulses, output bit onehot_ok);
    pulses    = 0;
    onehot_ok = 1'b1;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (kif.key_valid) pulses++;
      if ($countones(~kif.col_out) != 1) onehot_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          pulses;
    logic        held;
    logic [3:0]  code;
  } vec_t;

  vec_t       vecs [13];
  logic [3:0] walk [4];
  int         p, acc;
  bit         ok;

  initial begin
    checks = 0;
    errors = 0;
    keys   = '0;
    rst    = 1'b1;

    vecs[0]  = '{16'h0040, 6, 1, 1'b1, 4'd6};   // press 6
    vecs[1]  = '{16'h0040, 4, 0, 1'b1, 4'd6};   // held, no repeat
    vecs[2]  = '{16'h0000, 4, 0, 1'b0, 4'd6};   // release
    vecs[3]  = '{16'h0040, 6, 1, 1'b1, 4'd6};   // re-press
    vecs[4]  = '{16'h0000, 4, 0, 1'b0, 4'd6};
    vecs[5]  = '{16'h0021, 6, 0, 1'b0, 4'd6};   // keys 0+5: multi
    vecs[6]  = '{16'h0020, 6, 1, 1'b1, 4'd5};   // release 0 -> 5
    vecs[7]  = '{16'h0000, 4, 0, 1'b0, 4'd5};
    vecs[8]  = '{16'h0200, 6, 1, 1'b1, 4'd9};   // press 9
    vecs[9]  = '{16'h1000, 4, 0, 1'b1, 4'd9};   // roll to 12: no rollover
    vecs[10] = '{16'h0000, 4, 0, 1'b0, 4'd9};
    vecs[11] = '{16'h1000, 6, 1, 1'b1, 4'd12};  // press 12
    vecs[12] = '{16'h0000, 4, 0, 1'b0, 4'd12};

    walk[0] = 4'b1101;
    walk[1] = 4'b1011;
    walk[2] = 4'b0111;
    walk[3] = 4'b1110;

    // Reset values and column walk.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col_out",   32'(kif.col_out),   32'hE);
    check("rst_key_code",  32'(kif.key_code),  32'h0);
    check("rst_key_valid", 32'(kif.key_valid), 32'h0);
    check("rst_key_held",  32'(kif.key_held),  32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("col_slot0_hold", 32'(kif.col_out), 32'hE);
    @(posedge clk);
    @(negedge clk);
    check("col_walk0", 32'(kif.col_out), 32'(walk[0]));
    for (int i = 1; i < 4; i++) begin
      repeat (SCAN_DIV) @(posedge clk);
      @(negedge clk);
      check($sformatf("col_walk%0d", i), 32'(kif.col_out), 32'(walk[i]));
    end

    // Table-driven press/release/multi vectors.
    for (int i = 0; i < 13; i++) begin
      keys = vecs[i].keys;
      run_cycles(vecs[i].scans * SCAN_CYC, p, ok);
      check($sformatf("v%0d_pulses", i), 32'(p), 32'(vecs[i].pulses));
      check($sformatf("v%0d_held", i),   32'(kif.key_held), 32'(vecs[i].held));
      check($sformatf("v%0d_code", i),   32'(kif.key_code), 32'(vecs[i].code));
      check($sformatf("v%0d_onehot", i), 32'(ok), 32'h1);
    end

    // Bounce on key 6, phase-locked to a fresh reset: at most one SINGLE scan in a row.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    acc = 0;
    for (int j = 0; j < 12; j++) begin
      keys = (j % 2 == 0) ? 16'h0040 : 16'h0000;
      run_cycles(5, p, ok);
      acc += p;
    end
    keys = '0;
    run_cycles(4 * SCAN_CYC, p, ok);
    acc += p;
    check("bounce_pulses", 32'(acc), 32'h0);
    check("bounce_held",   32'(kif.key_held), 32'h0);

    // Reset while key 15 is half debounced, then re-accept after release of reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    keys = 16'h8000;
    run_cycles(20, p, ok);
    acc = p;
    rst = 1'b1;
    run_cycles(3, p, ok);
    acc += p;
    check("k15_pre_rst_pulses", 32'(acc),           32'h0);
    check("k15_rst_held",       32'(kif.key_held),  32'h0);
    check("k15_rst_code",       32'(kif.key_code),  32'h0);
    check("k15_rst_col_out",    32'(kif.col_out),   32'hE);
    rst = 1'b0;
    run_cycles(2 * SCAN_CYC - 1, p, ok);
    check("k15_early_pulses", 32'(p), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("k15_valid",   32'(kif.key_valid), 32'h1);
    check("k15_code",    32'(kif.key_code),  32'hF);
    check("k15_held",    32'(kif.key_held),  32'h1);
    @(posedge clk);
    @(negedge clk);
    check("k15_valid_one_cycle", 32'(kif.key_valid), 32'h0);
    run_cycles(4 * SCAN_CYC, p, ok);
    check("k15_no_repeat", 32'(p), 32'h0);
    keys = '0;
    run_cycles(4 * SCAN_CYC, p, ok);
    check("k15_release_held", 32'(kif.key_held), 32'h0);
    check("k15_code_holds",   32'(kif.key_code), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
